// File: rtl/me_pe_sad_acc.sv
// Motion-estimation processing element: current-block store, reference pixel
// register, registered absolute difference and a framed, saturating SAD accumulator.
module me_pe_sad_acc #(
    parameter int PIXEL_W = 8,
    parameter int NUM_CB  = 4,
    parameter int ACC_W   = 16,
    parameter int SEL_W   = $clog2(NUM_CB)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PIXEL_W-1:0] in_curr,
    input  logic               in_curr_en,
    input  logic [SEL_W-1:0]   cb_wr_sel,
    output logic [PIXEL_W-1:0] next_pix,
    input  logic [PIXEL_W-1:0] up_ref_1,
    input  logic [PIXEL_W-1:0] up_ref_8,
    input  logic [PIXEL_W-1:0] down_ref_1,
    input  logic [PIXEL_W-1:0] down_ref_8,
    input  logic               change_ref,
    input  logic [1:0]         ref_sel,
    output logic [PIXEL_W-1:0] ref_pix,
    input  logic               abs_en,
    input  logic [SEL_W-1:0]   abs_sel,
    input  logic               acc_first,
    input  logic               acc_last,
    output logic [PIXEL_W-1:0] abs_out,
    output logic               abs_valid,
    output logic [ACC_W-1:0]   sad_out,
    output logic               sad_valid,
    output logic               sad_sat
);

    logic [PIXEL_W-1:0] cb_q [NUM_CB];
    logic [PIXEL_W-1:0] ref_pix_q, ref_pix_d;
    logic [PIXEL_W-1:0] cb_abs, abs_d;
    logic [PIXEL_W-1:0] abs_q;
    logic               abs_valid_q, first_q, last_q;
    logic [ACC_W-1:0]   acc_q, sad_q, base, sum_d;
    logic [ACC_W:0]     sum_wide;
    logic               sticky_q, sad_valid_q, sad_sat_q, sat, sticky_base;

    // NOTE: the CB array is small and feeds next_pix directly, so it is reset
    // like any other register; otherwise the next PE would see X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CB; i++) cb_q[i] <= '0;
        end else if (in_curr_en) begin
            for (int i = 0; i < NUM_CB; i++)
                if (cb_wr_sel == SEL_W'(i)) cb_q[i] <= in_curr;
        end
    end

    // Out-of-range selects match no entry and therefore read as zero.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_pix = '0;
        cb_abs   = '0;
        for (int i = 0; i < NUM_CB; i++) begin
            if (cb_wr_sel == SEL_W'(i)) next_pix = cb_q[i];
            if (abs_sel == SEL_W'(i))   cb_abs   = cb_q[i];
        end
    end

    always_comb begin
        ref_pix_d = ref_pix_q;
        if (change_ref) begin
            case (ref_sel)
                2'd0:    ref_pix_d = up_ref_1;
                2'd1:    ref_pix_d = up_ref_8;
                2'd2:    ref_pix_d = down_ref_1;
                default: ref_pix_d = down_ref_8;
            endcase
        end
    end

    // Difference uses pre-edge CB and ref_pix, so same-cycle updates do not leak in.
    assign abs_d = (cb_abs >= ref_pix_q) ? (cb_abs - ref_pix_q) : (ref_pix_q - cb_abs);

    always_comb begin
        base        = first_q ? '0 : acc_q;
        sticky_base = first_q ? 1'b0 : sticky_q;
        sum_wide    = {1'b0, base} + {{(ACC_W + 1 - PIXEL_W){1'b0}}, abs_q};
        sat         = sum_wide[ACC_W];
        sum_d       = sat ? '1 : sum_wide[ACC_W-1:0];
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, which is what gives back-to-back SADs no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_pix_q   <= '0;
            abs_q       <= '0;
            abs_valid_q <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            sad_q       <= '0;
            sad_valid_q <= 1'b0;
            sad_sat_q   <= 1'b0;
        end else begin
            ref_pix_q   <= ref_pix_d;
            abs_valid_q <= abs_en;
            first_q     <= abs_en & acc_first;
            last_q      <= abs_en & acc_last;
            if (abs_en) abs_q <= abs_d;

            sad_valid_q <= 1'b0;
            if (abs_valid_q) begin
                if (last_q) begin
                    sad_q       <= sum_d;
                    sad_sat_q   <= sticky_base | sat;
                    sad_valid_q <= 1'b1;
                    acc_q       <= '0;
                    sticky_q    <= 1'b0;
                end else begin
                    acc_q    <= sum_d;
                    sticky_q <= sticky_base | sat;
                end
            end
        end
    end

    assign ref_pix   = ref_pix_q;
    assign abs_out   = abs_q;
    assign abs_valid = abs_valid_q;
    assign sad_out   = sad_q;
    assign sad_valid = sad_valid_q;
    assign sad_sat   = sad_sat_q;

endmodule

// File: tb/tb_me_pe_sad_acc.sv
// Self-checking bench for me_pe_sad_acc: two instances (16-bit and 9-bit SAD)
// share one stimulus stream and are checked against a transaction-level model.
module tb_me_pe_sad_acc;

    localparam int PW  = 8;
    localparam int NCB = 4;
    localparam int SW  = 3;
    localparam int MAX_A = 65535;
    localparam int MAX_B = 511;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [PW-1:0] in_curr, up_ref_1, up_ref_8, down_ref_1, down_ref_8;
    logic          in_curr_en, change_ref, abs_en, acc_first, acc_last;
    logic [SW-1:0] cb_wr_sel, abs_sel;
    logic [1:0]    ref_sel;

    logic [PW-1:0] next_pix_a, ref_pix_a, abs_out_a, next_pix_b, ref_pix_b, abs_out_b;
    logic          abs_valid_a, sad_valid_a, sad_sat_a, abs_valid_b, sad_valid_b, sad_sat_b;
    logic [15:0]   sad_out_a;
    logic [8:0]    sad_out_b;

    me_pe_sad_acc #(.PIXEL_W(PW), .NUM_CB(NCB), .ACC_W(16), .SEL_W(SW)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_curr(in_curr), .in_curr_en(in_curr_en),
        .cb_wr_sel(cb_wr_sel), .next_pix(next_pix_a), .up_ref_1(up_ref_1),
        .up_ref_8(up_ref_8), .down_ref_1(down_ref_1), .down_ref_8(down_ref_8),
        .change_ref(change_ref), .ref_sel(ref_sel), .ref_pix(ref_pix_a),
        .abs_en(abs_en), .abs_sel(abs_sel), .acc_first(acc_first), .acc_last(acc_last),
        .abs_out(abs_out_a), .abs_valid(abs_valid_a), .sad_out(sad_out_a),
        .sad_valid(sad_valid_a), .sad_sat(sad_sat_a)
    );

    me_pe_sad_acc #(.PIXEL_W(PW), .NUM_CB(NCB), .ACC_W(9), .SEL_W(SW)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_curr(in_curr), .in_curr_en(in_curr_en),
        .cb_wr_sel(cb_wr_sel), .next_pix(next_pix_b), .up_ref_1(up_ref_1),
        .up_ref_8(up_ref_8), .down_ref_1(down_ref_1), .down_ref_8(down_ref_8),
        .change_ref(change_ref), .ref_sel(ref_sel), .ref_pix(ref_pix_b),
        .abs_en(abs_en), .abs_sel(abs_sel), .acc_first(acc_first), .acc_last(acc_last),
        .abs_out(abs_out_b), .abs_valid(abs_valid_b), .sad_out(sad_out_b),
        .sad_valid(sad_valid_b), .sad_sat(sad_sat_b)
    );

    int total = 0;
    int passed = 0;
    int fails = 0;

    // Reference model: pixel store, reference pixel, running SAD total in plain ints.
    int m_cb [NCB];
    int m_ref, tot;
    int exp_abs, exp_sad_a, exp_sad_b;
    bit exp_absv, exp_sadv, exp_sat_a, exp_sat_b;
    bit pend_v, pend_sat_a, pend_sat_b;
    int pend_a, pend_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int cb_val(input int sel);
        return (sel < NCB) ? m_cb[sel] : 0;
    endfunction

    task automatic check_outs();
        check("next_pix_a", 32'(next_pix_a), cb_val(int'(cb_wr_sel)));
        check("next_pix_b", 32'(next_pix_b), cb_val(int'(cb_wr_sel)));
        check("ref_pix",    32'(ref_pix_a),  m_ref);
        check("abs_out",    32'(abs_out_a),  exp_abs);
        check("abs_valid",  32'(abs_valid_a), 32'(exp_absv));
        check("sad_out_a",  32'(sad_out_a),  exp_sad_a);
        check("sad_valid_a", 32'(sad_valid_a), 32'(exp_sadv));
        check("sad_sat_a",  32'(sad_sat_a),  32'(exp_sat_a));
        check("sad_out_b",  32'(sad_out_b),  exp_sad_b);
        check("sad_valid_b", 32'(sad_valid_b), 32'(exp_sadv));
        check("sad_sat_b",  32'(sad_sat_b),  32'(exp_sat_b));
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NCB; i++) m_cb[i] = 0;
        m_ref = 0; tot = 0; exp_abs = 0; exp_absv = 0;
        exp_sad_a = 0; exp_sad_b = 0; exp_sadv = 0; exp_sat_a = 0; exp_sat_b = 0;
        pend_v = 0;
    endfunction

    // One clock: model the result from the inputs presented before the edge,
    // then clear single-cycle strobes and compare every output.
    task automatic step();
        int c, diff, refs[4], wsel, wval, rsel;
        bit wr, cr, ab, f, l;
        c = cb_val(int'(abs_sel));
        diff = (c > m_ref) ? c - m_ref : m_ref - c;
        refs[0] = up_ref_1; refs[1] = up_ref_8; refs[2] = down_ref_1; refs[3] = down_ref_8;
        wr = in_curr_en; wsel = cb_wr_sel; wval = in_curr;
        cr = change_ref; rsel = ref_sel;
        ab = abs_en; f = acc_first; l = acc_last;
        @(posedge clk);
        #1;
        exp_sadv = pend_v;
        if (pend_v) begin
            exp_sad_a = pend_a; exp_sat_a = pend_sat_a;
            exp_sad_b = pend_b; exp_sat_b = pend_sat_b;
        end
        pend_v = 0;
        exp_absv = ab;
        if (ab) begin
            exp_abs = diff;
            if (f) tot = 0;
            tot += diff;
            if (l) begin
                pend_v = 1;
                pend_a = (tot > MAX_A) ? MAX_A : tot; pend_sat_a = tot > MAX_A;
                pend_b = (tot > MAX_B) ? MAX_B : tot; pend_sat_b = tot > MAX_B;
                tot = 0;
            end
        end
        if (wr && wsel < NCB) m_cb[wsel] = wval;
        if (cr) m_ref = refs[rsel];
        in_curr_en = 0; change_ref = 0; abs_en = 0; acc_first = 0; acc_last = 0;
        check_outs();
    endtask

    task automatic write_cb(input int idx, input int val);
        in_curr_en = 1; cb_wr_sel = SW'(idx); in_curr = PW'(val);
        step();
    endtask

    task automatic load_ref(input int sel);
        change_ref = 1; ref_sel = 2'(sel);
        step();
    endtask

    task automatic sample(input int sel, input bit f, input bit l);
        abs_en = 1; abs_sel = SW'(sel); acc_first = f; acc_last = l;
        step();
    endtask

    initial begin
        rst_n = 0;
        in_curr = 0; in_curr_en = 0; cb_wr_sel = 0; change_ref = 0; ref_sel = 0;
        up_ref_1 = 0; up_ref_8 = 0; down_ref_1 = 0; down_ref_8 = 0;
        abs_en = 0; abs_sel = 0; acc_first = 0; acc_last = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs();
        rst_n = 1;
        step();

        // CB write and next_pix select, including an out-of-range index.
        write_cb(2, 200);
        cb_wr_sel = 3'd7; #1;
        check_outs();
        write_cb(7, 99);
        for (int i = 0; i < NCB; i++) begin
            cb_wr_sel = SW'(i); #1;
            check_outs();
        end

        // Reference source sweep, then hold.
        up_ref_1 = 10; up_ref_8 = 20; down_ref_1 = 30; down_ref_8 = 40;
        for (int i = 0; i < 4; i++) load_ref(i);
        ref_sel = 0; step();
        check("ref_hold", 32'(ref_pix_b), 40);

        // Absolute difference both directions and a same-cycle CB0 write.
        write_cb(0, 50);
        up_ref_1 = 80; load_ref(0);
        sample(0, 0, 0);
        write_cb(0, 80);
        up_ref_1 = 50; load_ref(0);
        sample(0, 0, 0);
        in_curr_en = 1; cb_wr_sel = 0; in_curr = 0;
        sample(0, 0, 0);
        step();

        // Four-sample SAD 30+5+0+255 = 290, then back-to-back single sample of 7.
        up_ref_1 = 0; load_ref(0);
        write_cb(0, 30); write_cb(1, 5); write_cb(2, 0); write_cb(3, 255);
        sample(0, 1, 0); sample(1, 0, 0); sample(2, 0, 0);
        in_curr_en = 1; cb_wr_sel = 1; in_curr = 7;
        sample(3, 0, 1);
        sample(1, 1, 1);
        step();
        check("sad_7", 32'(sad_out_a), 7);
        step();

        // 3 x 255 saturates the 9-bit instance, the next SAD clears the flag.
        sample(3, 1, 0); sample(3, 0, 0); sample(3, 0, 1);
        step();
        check("sat_9bit", 32'(sad_sat_b), 1);
        write_cb(2, 1);
        sample(2, 1, 1);
        step(); step();

        // Reset mid-SAD discards the partial sum.
        sample(3, 1, 0); sample(3, 0, 0);
        rst_n = 0; #2;
        model_reset();
        check_outs();
        @(posedge clk); #1;
        rst_n = 1;
        step();
        write_cb(1, 4);
        sample(1, 1, 1);
        step(); step();

        // Randomised traffic, including same-cycle writes, reloads and framing.
        for (int n = 0; n < 300; n++) begin
            in_curr_en = 1'($urandom_range(0, 1));
            cb_wr_sel  = SW'($urandom_range(0, 7));
            in_curr    = PW'($urandom);
            change_ref = ($urandom_range(0, 3) == 0);
            ref_sel    = 2'($urandom_range(0, 3));
            up_ref_1   = PW'($urandom); up_ref_8   = PW'($urandom);
            down_ref_1 = PW'($urandom); down_ref_8 = PW'($urandom);
            abs_en     = ($urandom_range(0, 3) != 0);
            abs_sel    = SW'($urandom_range(0, 7));
            acc_first  = ($urandom_range(0, 4) == 0);
            acc_last   = ($urandom_range(0, 4) == 0);
            step();
        end
        step(); step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
